// File: rtl/fm_tx_pkg.sv
// Shared definitions for the FM transmitter sample path: sample width,
// byte order of the UART sample stream and a constant-foldable gcd helper.
package fm_tx_pkg;

  localparam int SAMPLE_W  = 16;
  // Samples arrive as little-endian byte pairs: low byte first.
  localparam bit LSB_FIRST = 1'b1;

  typedef enum logic [0:0] {
    PREFILL = 1'b0,
    PLAY    = 1'b1
  } pacer_state_e;

  // Greatest common divisor, used at elaboration to reduce the tick ratio.
  function automatic longint gcd(input longint a, input longint b);
    longint x;
    longint y;
    longint t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Combine two received bytes into one sample according to the byte order.
  function automatic logic [SAMPLE_W-1:0] packBytes(input logic [7:0] firstByte,
                                                    input logic [7:0] secondByte);
    if (LSB_FIRST) return {secondByte, firstByte};
    else           return {firstByte, secondByte};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO for audio samples. A push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module sample_fifo
  import fm_tx_pkg::*;
#(
  parameter int WIDTH      = SAMPLE_W,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk_i,
  input  logic                  resetN_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      pushData_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  doPush;
  logic                  doPop;

  assign full_o  = (level_q == FULL_LEVEL);
  assign empty_o = (level_q == '0);
  assign head_o  = mem_q[rdPtr_q];
  assign level_o = level_q;
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);

  // Next pointers and occupancy from the accepted push/pop pair.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
    if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
    if (doPush && !doPop)      level_d = level_q + LEVEL_ONE;
    else if (doPop && !doPush) level_d = level_q - LEVEL_ONE;
  end

  // Pointer and level registers; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge resetN_i) begin
    if (!resetN_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/uart_sample_pacer.sv
// Packs UART bytes into signed 16-bit samples, buffers them and releases one
// sample per period of a fractional-rate tick so the modulator sees an exact,
// jitter-free sample stream. Prefill, underrun, overflow and line-gap resync
// are handled here.
module uart_sample_pacer
  import fm_tx_pkg::*;
#(
  parameter int clockRate     = 76_800_000,
  parameter int sampleRate    = 192_000,
  parameter int fifoDepthLog2 = 6,
  parameter int prefillLevel  = 32,
  parameter int gapCycles     = 1024
) (
  input  logic                     clk_i,
  input  logic                     resetN_i,
  input  logic                     available_i,
  input  logic [7:0]               data_i,
  output logic                     sampleValid_o,
  output logic [SAMPLE_W-1:0]      sample_o,
  output logic                     underrun_o,
  output logic                     overflow_o,
  output logic [fifoDepthLog2:0]   level_o
);

  localparam longint TICK_G  = gcd(longint'(sampleRate), longint'(clockRate));
  localparam longint TICK_N  = longint'(sampleRate) / TICK_G;
  localparam longint TICK_D  = longint'(clockRate) / TICK_G;
  localparam int     ACC_W   = $clog2(TICK_D) + 1;
  localparam logic [ACC_W-1:0] ACC_N = ACC_W'(TICK_N);
  localparam logic [ACC_W-1:0] ACC_D = ACC_W'(TICK_D);

  localparam int               GAP_W   = $clog2(gapCycles + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(gapCycles);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  localparam logic [fifoDepthLog2:0] PREFILL_LVL = (fifoDepthLog2 + 1)'(prefillLevel);

  // Tick accumulator
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] accSum;
  logic             tick;

  // Byte assembler
  logic                phase_q, phase_d;
  logic [7:0]          lowByte_q, lowByte_d;
  logic [GAP_W-1:0]    gapCnt_q, gapCnt_d;
  logic                pushValid_q, pushValid_d;
  logic [SAMPLE_W-1:0] pushData_q, pushData_d;

  // Playout FSM and registered outputs
  pacer_state_e        state_q, state_d;
  logic                sampleValid_q, sampleValid_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                underrun_q, underrun_d;
  logic                pop;

  // FIFO status
  logic [SAMPLE_W-1:0]    fifoHead;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic [fifoDepthLog2:0] fifoLevel;

  sample_fifo #(
    .WIDTH      (SAMPLE_W),
    .DEPTH_LOG2 (fifoDepthLog2)
  ) u_fifo (
    .clk_i      (clk_i),
    .resetN_i   (resetN_i),
    .push_i     (pushValid_q),
    .pushData_i (pushData_q),
    .pop_i      (pop),
    .head_o     (fifoHead),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .level_o    (fifoLevel)
  );

  // Fractional-rate tick: add N each cycle, wrap by D and fire on the wrap.
  always_comb begin
    accSum = acc_q + ACC_N;
    tick   = (accSum >= ACC_D);
    acc_d  = tick ? (accSum - ACC_D) : accSum;
  end

  // Pair bytes into samples; a long idle line drops a dangling low byte.
  always_comb begin
    phase_d     = phase_q;
    lowByte_d   = lowByte_q;
    gapCnt_d    = gapCnt_q;
    pushValid_d = 1'b0;
    pushData_d  = pushData_q;
    if (available_i) begin
      gapCnt_d = '0;
      if (!phase_q) begin
        lowByte_d = data_i;
        phase_d   = 1'b1;
      end else begin
        pushValid_d = 1'b1;
        pushData_d  = packBytes(lowByte_q, data_i);
        phase_d     = 1'b0;
      end
    end else begin
      if (gapCnt_q != GAP_MAX) gapCnt_d = gapCnt_q + GAP_ONE;
      if (phase_q && (gapCnt_d == GAP_MAX)) phase_d = 1'b0;
    end
  end

  // Playout FSM: emit a pulse on every tick, popping only while in PLAY.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    sampleValid_d = 1'b0;
    sample_d      = sample_q;
    underrun_d    = 1'b0;
    case (state_q)
      PREFILL: begin
        if (tick) begin
          sampleValid_d = 1'b1;
          sample_d      = '0;
        end
        if (fifoLevel >= PREFILL_LVL) state_d = PLAY;
      end
      PLAY: begin
        if (tick) begin
          sampleValid_d = 1'b1;
          if (!fifoEmpty) begin
            pop      = 1'b1;
            sample_d = fifoHead;
          end else begin
            sample_d   = '0;
            underrun_d = 1'b1;
            state_d    = PREFILL;
          end
        end
      end
      default: state_d = PREFILL;
    endcase
  end

  // All sequential state; reset discards any partial sample and restarts the tick.
  always_ff @(posedge clk_i or negedge resetN_i) begin
    if (!resetN_i) begin
      acc_q         <= '0;
      phase_q       <= 1'b0;
      lowByte_q     <= '0;
      gapCnt_q      <= '0;
      pushValid_q   <= 1'b0;
      pushData_q    <= '0;
      state_q       <= PREFILL;
      sampleValid_q <= 1'b0;
      sample_q      <= '0;
      underrun_q    <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      phase_q       <= phase_d;
      lowByte_q     <= lowByte_d;
      gapCnt_q      <= gapCnt_d;
      pushValid_q   <= pushValid_d;
      pushData_q    <= pushData_d;
      state_q       <= state_d;
      sampleValid_q <= sampleValid_d;
      sample_q      <= sample_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sampleValid_o = sampleValid_q;
  assign sample_o      = sample_q;
  assign underrun_o    = underrun_q;
  assign overflow_o    = pushValid_q && fifoFull && !pop;
  assign level_o       = fifoLevel;

endmodule

// File: tb/tb_uart_sample_pacer.sv
// Scenario bench for uart_sample_pacer: expected samples are queued as pairs
// are sent and popped as the DUT releases them during PLAY.
module tb_uart_sample_pacer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        available;
  logic [7:0]  data;
  logic        sampleValid;
  logic [15:0] sample;
  logic        underrun;
  logic        overflow;
  logic [6:0]  level;

  int nVec = 0;
  int nErr = 0;
  logic [15:0] expQ[$];

  always #5 clk = ~clk;

  uart_sample_pacer #(
    .clockRate     (76_800_000),
    .sampleRate    (192_000),
    .fifoDepthLog2 (6),
    .prefillLevel  (32),
    .gapCycles     (1024)
  ) dut (
    .clk_i         (clk),
    .resetN_i      (resetN),
    .available_i   (available),
    .data_i        (data),
    .sampleValid_o (sampleValid),
    .sample_o      (sample),
    .underrun_o    (underrun),
    .overflow_o    (overflow),
    .level_o       (level)
  );

  task automatic applyReset();
    available = 1'b0;
    data      = 8'h00;
    resetN    = 1'b0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    expQ.delete();
  endtask

  task automatic sendByte(input logic [7:0] b);
    available = 1'b1;
    data      = b;
    @(negedge clk);
    available = 1'b0;
    data      = 8'h00;
  endtask

  task automatic sendPair(input logic [15:0] s, input bit accept);
    sendByte(s[7:0]);
    sendByte(s[15:8]);
    if (accept) expQ.push_back(s);
  endtask

  task automatic waitTick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (sampleValid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nVec++;
      nErr++;
      $display("[TB] FAIL tick_timeout: no sampleValid within 1000 cycles");
    end
  endtask

  function automatic logic [15:0] nextExp();
    if (expQ.size() > 0) return expQ.pop_front();
    return 16'h0000;
  endfunction

  task automatic test_reset();
    available = 1'b0;
    data      = 8'h00;
    resetN    = 1'b0;
    #12;
    nVec++;
    if ({sampleValid, sample, underrun, overflow, level} !== 26'd0) begin
      nErr++;
      $display("[TB] FAIL reset_outputs: got valid=%0b sample=%h under=%0b over=%0b level=%0d, want all 0",
               sampleValid, sample, underrun, overflow, level);
    end
    applyReset();
  endtask

  task automatic test_tick_spacing();
    int cnt;
    int expSpace;
    applyReset();
    for (int p = 0; p < 5; p++) begin
      cnt = 0;
      expSpace = 400;
      do begin
        @(negedge clk);
        cnt++;
      end while (!sampleValid && cnt < 1000);
      nVec++;
      if (cnt !== expSpace) begin
        nErr++;
        $display("[TB] FAIL tick_spacing[%0d]: got %0d cycles, want %0d", p, cnt, expSpace);
      end
      nVec++;
      if (sample !== 16'h0000) begin
        nErr++;
        $display("[TB] FAIL prefill_sample[%0d]: got %h, want 0000", p, sample);
      end
    end
  endtask

  task automatic test_fill_play();
    bit ok;
    logic [15:0] exp;
    applyReset();
    for (int i = 0; i < 32; i++) sendPair(16'h1234 + 16'(i) * 16'h0101, 1'b1);
    @(negedge clk);
    nVec++;
    if (level !== 7'd32) begin
      nErr++;
      $display("[TB] FAIL fill_level: got %0d, want 32", level);
    end
    for (int k = 1; k <= 4; k++) begin
      waitTick(ok);
      exp = nextExp();
      nVec++;
      if (sample !== exp) begin
        nErr++;
        $display("[TB] FAIL play_sample[%0d]: got %h, want %h", k, sample, exp);
      end
      nVec++;
      if (level !== 7'(32 - k)) begin
        nErr++;
        $display("[TB] FAIL play_level[%0d]: got %0d, want %0d", k, level, 32 - k);
      end
    end
  endtask

  task automatic test_gap_discard();
    bit ok;
    logic [15:0] exp;
    applyReset();
    sendByte(8'hCD);
    repeat (1024) @(negedge clk);
    sendPair(16'h8001, 1'b1);
    @(negedge clk);
    nVec++;
    if (level !== 7'd1) begin
      nErr++;
      $display("[TB] FAIL gap_level: got %0d, want 1", level);
    end
    waitTick(ok);
    for (int i = 0; i < 31; i++) sendPair(16'h4000 + 16'(i), 1'b1);
    waitTick(ok);
    exp = nextExp();
    nVec++;
    if (sample !== exp) begin
      nErr++;
      $display("[TB] FAIL gap_sample: got %h, want %h", sample, exp);
    end
  endtask

  task automatic test_underrun();
    bit ok;
    int bad;
    logic [15:0] exp;
    applyReset();
    waitTick(ok);
    for (int i = 0; i < 64; i++) sendPair(16'(i * 977 + 5), 1'b1);
    @(negedge clk);
    nVec++;
    if (level !== 7'd64) begin
      nErr++;
      $display("[TB] FAIL full_level: got %0d, want 64", level);
    end
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      waitTick(ok);
      exp = nextExp();
      nVec++;
      if (sample !== exp || underrun !== 1'b0) begin
        nErr++;
        $display("[TB] FAIL drain_sample[%0d]: got %h under=%0b, want %h under=0", k, sample, underrun, exp);
      end
    end
    waitTick(ok);
    nVec++;
    if (underrun !== 1'b1 || sample !== 16'h0000) begin
      nErr++;
      $display("[TB] FAIL underrun_pulse: got under=%0b sample=%h, want under=1 sample=0000", underrun, sample);
    end
    @(negedge clk);
    nVec++;
    if (underrun !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL underrun_width: got %0b, want 0", underrun);
    end
    sendPair(16'h7777, 1'b1);
    waitTick(ok);
    nVec++;
    if (underrun !== 1'b0 || sample !== 16'h0000 || level !== 7'd1) begin
      nErr++;
      $display("[TB] FAIL after_underrun: got under=%0b sample=%h level=%0d, want 0 0000 1", underrun, sample, level);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [15:0] exp;
    applyReset();
    waitTick(ok);
    for (int i = 0; i < 64; i++) sendPair(16'hA000 + 16'(i), 1'b1);
    sendPair(16'hDEAD, 1'b0);
    nVec++;
    if (overflow !== 1'b1 || level !== 7'd64) begin
      nErr++;
      $display("[TB] FAIL overflow_pulse: got over=%0b level=%0d, want 1 64", overflow, level);
    end
    @(negedge clk);
    nVec++;
    if (overflow !== 1'b0 || level !== 7'd64) begin
      nErr++;
      $display("[TB] FAIL overflow_after: got over=%0b level=%0d, want 0 64", overflow, level);
    end
    waitTick(ok);
    exp = nextExp();
    nVec++;
    if (sample !== exp) begin
      nErr++;
      $display("[TB] FAIL overflow_head: got %h, want %h", sample, exp);
    end
    sendPair(16'h5A5A, 1'b1);
    repeat (395) @(negedge clk);
    sendPair(16'hBEEF, 1'b1);
    nVec++;
    if (overflow !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL aligned_overflow: got %0b, want 0", overflow);
    end
    @(negedge clk);
    exp = nextExp();
    nVec++;
    if (sampleValid !== 1'b1 || sample !== exp || level !== 7'd64) begin
      nErr++;
      $display("[TB] FAIL aligned_pushpop: got valid=%0b sample=%h level=%0d, want 1 %h 64",
               sampleValid, sample, level, exp);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [15:0] exp;
    applyReset();
    waitTick(ok);
    for (int i = 0; i < 20; i++) sendPair(16'h3000 + 16'(i), 1'b1);
    @(negedge clk);
    nVec++;
    if (level !== 7'd20) begin
      nErr++;
      $display("[TB] FAIL pre_reset_level: got %0d, want 20", level);
    end
    sendByte(8'hAA);
    #2;
    resetN = 1'b0;
    #1;
    nVec++;
    if ({sampleValid, sample, underrun, overflow, level} !== 26'd0) begin
      nErr++;
      $display("[TB] FAIL async_reset: got valid=%0b sample=%h under=%0b over=%0b level=%0d, want all 0",
               sampleValid, sample, underrun, overflow, level);
    end
    @(negedge clk);
    resetN = 1'b1;
    expQ.delete();
    sendPair(16'h5678, 1'b1);
    for (int i = 0; i < 31; i++) sendPair(16'h6000 + 16'(i), 1'b1);
    waitTick(ok);
    exp = nextExp();
    nVec++;
    if (sample !== exp) begin
      nErr++;
      $display("[TB] FAIL fresh_pair: got %h, want %h", sample, exp);
    end
  endtask

  initial begin
    test_reset();
    test_tick_spacing();
    test_fill_play();
    test_gap_discard();
    test_underrun();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
